// File: rtl/scaler_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : scaler_frame_ctrl
// Purpose  : Frame/line sequencer for the scaler: drives the horizontal run
//            enable, steps the vertical accumulator and requests source lines.
// Revision : 1.0 - initial release
// ============================================================================
module scaler_frame_ctrl #(
    parameter int H_OUT  = 800,
    parameter int V_OUT  = 480,
    parameter int HBLANK = 16
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iSTART,
    input  logic [7:0] iH_FACTOR,
    input  logic [7:0] iV_FACTOR,
    input  logic       iLINE_RDY,
    output logic       oLINE_REQ,
    output logic       oH_EN,
    output logic [7:0] oH_FACTOR,
    output logic [6:0] oV_WEIGHT,
    output logic [9:0] oLINE_CNT,
    output logic       oBUSY,
    output logic       oDONE
);

    localparam int CW = $clog2(((H_OUT > HBLANK) ? H_OUT : HBLANK) + 1);
    localparam logic [CW-1:0] c_LINE_LAST = CW'(H_OUT - 1);
    localparam logic [CW-1:0] c_GAP_LAST  = CW'(HBLANK - 1);
    localparam logic [9:0]    c_VLAST     = 10'(V_OUT - 1);
    localparam logic [7:0]    c_UNITY     = 8'd128;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRIME = 3'd1,
        S_WAIT  = 3'd2,
        S_LINE  = 3'd3,
        S_GAP   = 3'd4,
        S_FETCH = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_step;
    logic [6:0]    r_vacc;
    logic          r_carry;
    logic [7:0]    r_hfac;
    logic [6:0]    r_vweight;
    logic [9:0]    r_line;

    logic          w_line_end;
    logic          w_gap_first;
    logic          w_gap_last;
    logic          w_accept;
    logic [7:0]    w_sum;
    logic          w_req;
    logic          w_hen;
    logic          w_busy;
    logic          w_done;

    assign w_line_end  = (r_state == S_LINE) && (r_cnt == c_LINE_LAST);
    assign w_gap_first = (r_state == S_GAP)  && (r_cnt == '0);
    assign w_gap_last  = (r_state == S_GAP)  && (r_cnt == c_GAP_LAST);
    assign w_accept    = (r_state == S_IDLE) && iSTART;
    // Step is clamped to 1.0, so the 8-bit sum never overflows.
    assign w_sum       = {1'b0, r_vacc} + r_step;

    always_comb begin
        w_next = r_state;
        w_req  = 1'b0;
        w_hen  = 1'b0;
        w_busy = 1'b1;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy = 1'b0;
                if (iSTART) w_next = S_PRIME;
            end
            S_PRIME, S_FETCH: begin
                w_req  = 1'b1;
                w_next = S_WAIT;
            end
            S_WAIT: begin
                if (iLINE_RDY) w_next = S_LINE;
            end
            S_LINE: begin
                w_hen = 1'b1;
                if (w_line_end) w_next = S_GAP;
            end
            S_GAP: begin
                if (w_gap_last) begin
                    if (r_line == c_VLAST) w_next = S_DONE;
                    else if (r_carry)      w_next = S_FETCH;
                    else                   w_next = S_LINE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_busy = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_step    <= '0;
            r_vacc    <= '0;
            r_carry   <= 1'b0;
            r_hfac    <= '0;
            r_vweight <= '0;
            r_line    <= '0;
        end else begin
            r_state <= w_next;
            // Counter restarts on every state change, so it times LINE and GAP.
            if (w_next != r_state)
                r_cnt <= '0;
            else if (r_state == S_LINE || r_state == S_GAP)
                r_cnt <= r_cnt + 1'b1;

            if (w_accept) begin
                r_hfac    <= iH_FACTOR;
                r_step    <= (iV_FACTOR > c_UNITY) ? c_UNITY : iV_FACTOR;
                r_vacc    <= '0;
                r_carry   <= 1'b0;
                r_vweight <= '0;
                r_line    <= '0;
            end

            if (w_gap_first) begin
                r_vacc    <= w_sum[6:0];
                r_carry   <= w_sum[7];
                r_vweight <= w_sum[6:0];
            end

            if (w_gap_last && (r_line != c_VLAST))
                r_line <= r_line + 10'd1;
        end
    end

    assign oLINE_REQ = w_req;
    assign oH_EN     = w_hen;
    assign oBUSY     = w_busy;
    assign oDONE     = w_done;
    assign oH_FACTOR = r_hfac;
    assign oV_WEIGHT = r_vweight;
    assign oLINE_CNT = r_line;

endmodule
`default_nettype wire

// File: doc/scaler_frame_ctrl.md
# scaler_frame_ctrl

Frame/line sequencer for the MTL2 photo scaler datapath. It owns the horizontal factor accumulator's run enable and factor input. It runs the vertical interpolation accumulator and produces the per-line vertical weight. It requests new source lines from the line-buffer reader through a request/ready handshake. One instance sits between the frame-start logic and the horizontal/vertical interpolation pipeline.

## Interface
Parameters:
- H_OUT, 800, output pixels per line; oH_EN high this many cycles per line
- V_OUT, 480, output lines per frame
- HBLANK, 16, idle cycles between lines; legal minimum 2

Ports:
- iCLK  in  1  single clock; all logic on rising edge
- iRST  in  1  synchronous, active-high reset
- iSTART  in  1  frame start pulse; honoured only in IDLE
- iH_FACTOR  in  8  horizontal step; latched at frame start
- iV_FACTOR  in  8  vertical step, 128 = 1.0; latched at frame start
- iLINE_RDY  in  1  line buffer holds the requested source line(s)
- oLINE_REQ  out  1  one-cycle pulse: advance the source line
- oH_EN  out  1  run enable to the horizontal factor accumulator
- oH_FACTOR  out  8  latched horizontal factor
- oV_WEIGHT  out  7  vertical weight; stable while oH_EN = 1
- oLINE_CNT  out  10  current output line index
- oBUSY  out  1  high from the cycle after accepted iSTART through DONE
- oDONE  out  1  one-cycle pulse at frame end

## Operation
- States: IDLE, PRIME, WAIT, LINE, GAP, FETCH, DONE.
- IDLE: with iSTART = 1, latch iH_FACTOR to oH_FACTOR.
  - Latch min(iV_FACTOR, 128) as the vertical step; values above 128 clamp to 128 (downscale is not supported).
  - Clear v_acc (7 bit), carry, and oLINE_CNT. Go to PRIME.
- PRIME: oLINE_REQ = 1 for one cycle; this preloads the line pair. Go to WAIT.
- FETCH: oLINE_REQ = 1 for one cycle. Go to WAIT.
- WAIT: hold until iLINE_RDY is sampled high, then go to LINE.
  - A stall of any length keeps oH_EN low.
- LINE: oH_EN = 1 for exactly H_OUT consecutive cycles, then go to GAP.
- GAP: lasts HBLANK cycles with oH_EN = 0.
  - On the first GAP cycle: sum = v_acc + step (8 bit); v_acc <= sum[6:0]; carry <= sum[7]; oV_WEIGHT <= sum[6:0].
  - On the last GAP cycle, branch in this order:
    - If oLINE_CNT = V_OUT−1, go to DONE.
    - Otherwise increment oLINE_CNT. If carry = 1, go to FETCH; else go to LINE.
- DONE: oDONE = 1 for one cycle. Go to IDLE.
- iSTART outside IDLE is ignored.
- iRST in any state:
  - Forces IDLE. Clears v_acc, carry, and all outputs.
  - The next frame needs a new iSTART.
  - A partial line is abandoned. oH_EN drops on the next cycle, which re-initialises the horizontal accumulator.
- Reset values: oLINE_REQ = 0, oH_EN = 0, oH_FACTOR = 0, oV_WEIGHT = 0, oLINE_CNT = 0, oBUSY = 0, oDONE = 0.

## Timing
- iSTART sampled at edge t: PRIME during cycle t+1 (oLINE_REQ = 1, oBUSY = 1), then WAIT from t+2.
- iLINE_RDY sampled high at edge r: oH_EN rises in cycle r+1.
  - If iLINE_RDY is already high on WAIT entry, WAIT lasts exactly one cycle.
- oV_WEIGHT updates on the first GAP cycle. It is constant for the whole following LINE.
- Line period without stall: H_OUT + HBLANK cycles. Fetch lines add 2 cycles (FETCH + WAIT) plus the ready latency.
- HBLANK ≥ 2 guarantees oH_EN low for at least 2 cycles, which re-initialises the horizontal accumulator between lines.
- The line after DONE has no trailing FETCH. oDONE occurs the cycle after the last GAP cycle.

## Test plan
Bench parameters: H_OUT = 8, V_OUT = 4, HBLANK = 3, iLINE_RDY tied high unless stated.
1. iV_FACTOR = 128 → oV_WEIGHT 0 on all lines; oLINE_REQ 4 pulses (PRIME + 3 FETCH); 4 oH_EN runs of 8 cycles; oDONE once; oLINE_CNT 0,1,2,3.
2. iV_FACTOR = 64 → oV_WEIGHT per line 0,64,0,64; oLINE_REQ only at PRIME and before line 2 (2 pulses).
3. iV_FACTOR = 200 → behaves identically to scenario 1 (clamped to 128); iH_FACTOR = 0x55 → oH_FACTOR = 0x55 for the whole frame.
4. iLINE_RDY held low 10 cycles after each oLINE_REQ → oH_EN stays low through the stall and rises exactly 1 cycle after iLINE_RDY rises; line contents and weights are unchanged.
5. iRST asserted on the 4th oH_EN cycle of line 1 → next cycle all outputs are 0 and state is IDLE; a new iSTART runs a full correct frame starting at oLINE_CNT = 0.
6. iSTART pulsed during LINE and GAP → ignored (no counter reset, no extra oLINE_REQ); iSTART in the cycle of oDONE → ignored; the next cycle (IDLE) accepts it.
